// File: rtl/pulse_train_pkg.sv
// -----------------------------------------------------------------------------
// pulse_train_pkg
// Shared definitions for the pulse train generator: FSM state encoding,
// pulse counter width and the default width of the inter-pulse gap field.
// Optional feature macro used by the top level: PULSE_TRAIN_ABORT_EN.
// -----------------------------------------------------------------------------
package pulse_train_pkg;

    localparam int CNT_W     = 3;
    localparam int GAP_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pulse_gap_timer.sv
// -----------------------------------------------------------------------------
// pulse_gap_timer
// Down-counter timing the low cycles between pulses.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   load_i     - load load_val_i into the counter (priority over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement the counter by one
//   zero_o     - counter currently holds zero
// -----------------------------------------------------------------------------
module pulse_gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [GAP_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    localparam logic [GAP_W-1:0] ONE_C  = GAP_W'(1'b1);
    localparam logic [GAP_W-1:0] ZERO_C = {GAP_W{1'b0}};

    logic [GAP_W-1:0] count_q;
    logic [GAP_W-1:0] count_d;

    // Next count: load wins over decrement, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = count_q - ONE_C;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= ZERO_C;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == ZERO_C);

endmodule

// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
// Emits a burst of pulse_num single-cycle pulses (0 encodes 8) separated by
// gap low cycles, then a one-cycle done strobe. All outputs come from flops.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   start     - burst request, only honoured in IDLE
//   pulse_num - pulses per burst, 0 means 8
//   gap       - low cycles between pulses, 0 means back-to-back
//   abort     - terminate burst (only with PULSE_TRAIN_ABORT_EN defined)
//   pulse     - one cycle high per pulse
//   busy      - high in every state except IDLE
//   done      - one-cycle strobe after the last pulse of a completed burst
//   sent_cnt  - pulses issued in the current burst, modulo 8
// Optional feature macro: PULSE_TRAIN_ABORT_EN.
// -----------------------------------------------------------------------------
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] pulse_num,
    input  logic [GAP_W-1:0] gap,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic             abort,
`endif
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             pulse_q, busy_q, done_q;
    logic             abort_s;
    logic             tmr_load_s, tmr_dec_s, tmr_zero_s;

`ifdef PULSE_TRAIN_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Timer is loaded with gap-1 so the GAP state lasts exactly gap cycles.
    pulse_gap_timer #(
        .GAP_W      (GAP_W)
    ) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_s),
        .load_val_i (gap_q - GAP_ONE),
        .dec_i      (tmr_dec_s),
        .zero_o     (tmr_zero_s)
    );

    // Next-state logic. The count is advanced on every entry to PULSE, so it
    // already includes the pulse being driven; the last pulse is the one where
    // the count equals the latched number (8 wraps to 0, matching num=0).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        gap_d      = gap_q;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort_s) begin
                    num_d   = pulse_num;
                    gap_d   = gap;
                    cnt_d   = CNT_ONE;
                    state_d = PULSE;
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE: begin
                if (abort_s) begin
                    state_d = IDLE;
                end else if (cnt_q == num_q) begin
                    state_d = DONE;
                end else if (gap_q == GAP_ZERO) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = PULSE;
                end else begin
                    tmr_load_s = 1'b1;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (abort_s) begin
                    state_d = IDLE;
                end else if (tmr_zero_s) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = PULSE;
                end else begin
                    tmr_dec_s = 1'b1;
                    state_d   = GAP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched burst fields and output flops (outputs decoded from the
    // next state so they are registered yet aligned with the state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            num_q   <= CNT_ZERO;
            gap_q   <= GAP_ZERO;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            gap_q   <= gap_d;
            pulse_q <= (state_d == PULSE);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign pulse    = pulse_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sent_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_gen
// Table-driven bench for pulse_train_gen plus directed multi-cycle sequences.
// Cycle 0 is the cycle in which start is presented; outputs are sampled 1 time
// unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_pulse_train_gen;
    import pulse_train_pkg::*;

    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       pulse_num;
    logic [GAP_W-1:0] gap;
`ifdef PULSE_TRAIN_ABORT_EN
    logic             abort;
`endif
    logic             pulse;
    logic             busy;
    logic             done;
    logic [2:0]       sent_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pulse_train_gen #(.GAP_W(GAP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pulse_num (pulse_num),
        .gap       (gap),
`ifdef PULSE_TRAIN_ABORT_EN
        .abort     (abort),
`endif
        .pulse     (pulse),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] pnum;
        logic [3:0] gap;
        int         exp_done;   // cycle in which done is high
        logic [2:0] exp_sent;   // sent_cnt during done
        int         exp_ovf;    // wraps of a downstream 3-bit pulse counter
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n, g, last, kth, err_p, err_b, done_at, done_cnt, ovf;
        logic [2:0] sent_at_done;
        logic [2:0] pc;
        logic       exp_p;
        logic [7:0] pmask, dmask, bmask;

        vecs[0] = '{3'd3, 4'd2,  8,  3'd3, 0};
        vecs[1] = '{3'd0, 4'd0,  9,  3'd0, 1};
        vecs[2] = '{3'd1, 4'd5,  2,  3'd1, 0};
        vecs[3] = '{3'd1, 4'd0,  2,  3'd1, 0};
        vecs[4] = '{3'd5, 4'd1,  10, 3'd5, 0};
        vecs[5] = '{3'd2, 4'd15, 18, 3'd2, 0};
        vecs[6] = '{3'd4, 4'd0,  5,  3'd4, 0};
        vecs[7] = '{3'd7, 4'd3,  26, 3'd7, 0};

        rst       = 1'b1;
        start     = 1'b0;
        pulse_num = 3'd0;
        gap       = 4'd0;
`ifdef PULSE_TRAIN_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) tick();
        check("reset_outputs", {pulse, busy, done, sent_cnt}, 6'd0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", {pulse, busy, done}, 3'd0);

        // ---- table-driven bursts ----
        for (int v = 0; v < 8; v++) begin
            pulse_num = vecs[v].pnum;
            gap       = vecs[v].gap;
            start     = 1'b1;
            tick();
            start     = 1'b0;
            pulse_num = 3'd6;   // mid-burst changes must be ignored
            gap       = 4'd3;
            n    = (vecs[v].pnum == 3'd0) ? 8 : int'(vecs[v].pnum);
            g    = int'(vecs[v].gap);
            last = 1 + (n - 1) * (g + 1);
            kth = 0; err_p = 0; err_b = 0; done_at = -1; done_cnt = 0; ovf = 0;
            pc = 3'd0; sent_at_done = 3'd0;
            for (int c = 1; c <= last + 2; c++) begin
                exp_p = (c <= last) && (((c - 1) % (g + 1)) == 0);
                if (exp_p) kth++;
                if (pulse !== exp_p || (exp_p && sent_cnt !== 3'(kth))) err_p++;
                if (busy !== (c <= last + 1)) err_b++;
                if (done === 1'b1) begin
                    if (done_at < 0) done_at = c;
                    done_cnt++;
                    sent_at_done = sent_cnt;
                end
                if (pulse === 1'b1) begin
                    if (pc == 3'd7) ovf++;
                    pc = pc + 3'd1;
                end
                if (c < last + 2) tick();
            end
            check($sformatf("v%0d_pulse_trace_errs", v), err_p, 0);
            check($sformatf("v%0d_busy_trace_errs", v), err_b, 0);
            check($sformatf("v%0d_done_cycle", v), done_at, vecs[v].exp_done);
            check($sformatf("v%0d_done_count", v), done_cnt, 1);
            check($sformatf("v%0d_sent_at_done", v), sent_at_done, vecs[v].exp_sent);
            check($sformatf("v%0d_overflows", v), ovf, vecs[v].exp_ovf);
        end

        // ---- start held high through a burst and its DONE cycle ----
        pulse_num = 3'd2;
        gap       = 4'd1;
        start     = 1'b1;
        pmask = 8'd0; dmask = 8'd0; bmask = 8'd0;
        tick();
        pulse_num = 3'd1;       // latched by the second burst only
        gap       = 4'd0;
        for (int c = 1; c <= 6; c++) begin
            pmask[c] = pulse;
            dmask[c] = done;
            bmask[c] = busy;
            if (c == 6) begin
                check("held_start_2nd_sent", sent_cnt, 3'd1);
                start = 1'b0;
            end
            if (c < 6) tick();
        end
        check("held_start_pulse_mask", pmask, 8'h4A);
        check("held_start_done_mask", dmask, 8'h10);
        check("held_start_busy_mask", bmask, 8'h5E);
        tick();
        check("held_start_2nd_done", done, 1'b1);
        tick();
        check("held_start_back_idle", busy, 1'b0);

        // ---- asynchronous reset in GAP after the 2nd of 5 pulses ----
        pulse_num = 3'd5;
        gap       = 4'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();      // now in cycle 5 (GAP)
        check("pre_reset_busy", {pulse, busy, sent_cnt}, 5'b01010);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {pulse, busy, done, sent_cnt}, 6'd0);
        tick();
        rst = 1'b0;
        done_cnt = 0; err_b = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done === 1'b1) done_cnt++;
            if (busy !== 1'b0) err_b++;
        end
        check("post_reset_no_done", done_cnt, 0);
        check("post_reset_idle", err_b, 0);
        pulse_num = 3'd1;
        gap       = 4'd7;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("post_reset_c1", {pulse, busy, done}, 3'b110);
        tick();
        check("post_reset_c2", {pulse, busy, done}, 3'b011);
        tick();
        check("post_reset_c3", {pulse, busy, done}, 3'b000);

`ifdef PULSE_TRAIN_ABORT_EN
        // ---- abort during the 3rd pulse of 6 ----
        pulse_num = 3'd6;
        gap       = 4'd1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();      // cycle 5: third pulse
        check("abort_pre_pulse", {pulse, sent_cnt}, 4'b1011);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_next_cycle", {pulse, busy, done, sent_cnt}, 6'b000011);
        done_cnt = 0; err_b = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done === 1'b1) done_cnt++;
            if (busy !== 1'b0 || sent_cnt !== 3'd3) err_b++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_held_idle", err_b, 0);
        abort     = 1'b1;
        start     = 1'b1;
        pulse_num = 3'd2;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_with_start_idle", {pulse, busy}, 2'b00);
        tick();
        check("abort_with_start_idle2", {pulse, busy}, 2'b00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 SHALL have parameter GAP_W, default 4, giving the width of the inter-pulse gap field.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: burst request, sampled only in IDLE.
REQ-005 SHALL have port pulse_num, input, 3 bits: pulses per burst; 0 encodes 8.
REQ-006 SHALL have port gap, input, GAP_W bits: low cycles between pulses; 0 means back-to-back.
REQ-007 SHALL have port abort, input, 1 bit: terminate burst (present only with PULSE_TRAIN_ABORT_EN).
REQ-008 SHALL have port pulse, output, 1 bit: registered pulse output, one cycle high per pulse.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle strobe after the final pulse of a completed burst.
REQ-011 SHALL have port sent_cnt, output, 3 bits: pulses issued in the current burst, modulo 8.

Function
REQ-012 SHALL implement FSM states IDLE, PULSE, GAP and DONE.
REQ-013 SHALL, in IDLE with start=1, latch pulse_num and gap, clear sent_cnt and enter PULSE.
REQ-014 SHALL hold pulse high for exactly the one cycle spent in PULSE, i.e. the cycle after the start edge.
REQ-015 SHALL increment sent_cnt on each PULSE cycle; the value wraps 7->0 on the 8th pulse.
REQ-016 SHALL, after a PULSE that is not the last, enter GAP for exactly the latched gap cycles, then re-enter PULSE.
REQ-017 SHALL, with latched gap=0, go PULSE->PULSE so that pulse stays high for N consecutive cycles.
REQ-018 SHALL, after the last pulse, spend exactly one cycle in DONE with done=1, then return to IDLE.
REQ-019 SHALL give a burst of N pulses with gap G a duration of N+(N-1)*G cycles of busy before DONE.
REQ-020 SHALL ignore start in every state except IDLE; pulse_num and gap changes mid-burst SHALL have no effect.
REQ-021 SHALL, on start=1 in the cycle DONE is active, ignore start; a new burst needs start while in IDLE.
REQ-022 SHALL keep pulse, done and busy free of glitches, all driven directly from flops.

Reset
REQ-023 SHALL, while rst=1, immediately force state=IDLE, pulse=0, busy=0, done=0, sent_cnt=0 and clear the latched fields.
REQ-024 SHALL, on rst mid-burst, drop pulse in the same cycle and SHALL NOT assert done.

Configuration
REQ-025 SHALL, with PULSE_TRAIN_ABORT_EN defined, include the abort port.
REQ-026 SHALL, with abort=1 in PULSE, GAP or DONE, return to IDLE next cycle with pulse=0, done=0 and sent_cnt held.
REQ-027 SHALL give abort priority over burst progress; abort in IDLE, including together with start, SHALL start nothing.
REQ-028 SHALL, with PULSE_TRAIN_ABORT_EN undefined, have no abort port, and bursts SHALL always complete.

Structure
REQ-029 SHALL take the state enum, the 3-bit count width and the GAP_W default from shared package pulse_train_pkg.
REQ-030 SHALL put the gap down-counter in sub-module pulse_gap_timer (load, decrement, zero flag).

Verification
REQ-031 SHALL test pulse_num=3, gap=2, start at cycle 0: pulse high in cycles 1, 4 and 7, done in cycle 8, sent_cnt=3.
REQ-032 SHALL test pulse_num=0, gap=0: pulse high in cycles 1-8; sent_cnt wraps to 0; the downstream 3-bit pulse counter reports overflow once.
REQ-033 SHALL test start held high during a burst: only one burst; the next burst begins one cycle after done.
REQ-034 SHALL test rst pulsed during the GAP after the 2nd of 5 pulses: all outputs 0 at once, no done, and IDLE accepts start after reset.
REQ-035 SHALL test, with PULSE_TRAIN_ABORT_EN, abort during the 3rd pulse of 6: pulse low next cycle, busy low, done never asserted, sent_cnt=3.
REQ-036 SHALL test pulse_num=1 with any gap: a single pulse in cycle 1, done in cycle 2, and the GAP state never entered.
